frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 Parameter FRAME_PIXELS, default 76800: pixel writes in one complete 320x240 frame.
REQ-002 Parameter TIMEOUT_CYC, default 24'd2000000: max pclk cycles spent in ARM plus CAPTURE before abort.
REQ-003 Parameter CONTINUOUS, default 0: 1 means re-arm automatically after release.
REQ-004 pclk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 vsync  input  1  camera vsync; high = vertical blanking.
REQ-007 cap_we  input  1  write strobe from pixel capture stage.
REQ-008 cap_addr  input  17  write address from pixel capture stage.
REQ-009 start  input  1  one-cycle request from NN side for a new frame.
REQ-010 release  input  1  one-cycle pulse: consumer finished reading the frozen frame.
REQ-011 abort  input  1  level; forces IDLE.
REQ-012 bram_we  output  1  gated frame-buffer write enable.
REQ-013 bram_addr  output  17  frame-buffer write address.
REQ-014 frame_ready  output  1  buffer holds one complete frozen frame.
REQ-015 busy  output  1  high in ARM or CAPTURE.
REQ-016 frame_cnt  output  8  count of completed frames, wraps 255->0.
REQ-017 short_err  output  1  one-cycle pulse: frame ended with wrong pixel count.
REQ-018 timeout_err  output  1  one-cycle pulse: timeout abort.

Function
REQ-019 States IDLE, ARM, CAPTURE, HOLD; encoding 2 bits.
REQ-020 vsync registered once (vsync_q); vs_rise = vsync & ~vsync_q, vs_fall = ~vsync & vsync_q.
REQ-021 IDLE: start -> ARM next cycle; all other inputs ignored.
REQ-022 ARM: vs_fall -> CAPTURE, pix_cnt cleared; capture never begins mid-frame.
REQ-023 CAPTURE: bram_we = cap_we when cap_addr < FRAME_PIXELS, combinational, zero latency; bram_we = 0 in every other state.
REQ-024 bram_addr = cap_addr in all states, combinational.
REQ-025 CAPTURE: each accepted write increments 17-bit pix_cnt, saturating at FRAME_PIXELS.
REQ-026 CAPTURE + vs_rise with pix_cnt == FRAME_PIXELS -> HOLD, frame_cnt incremented.
REQ-027 CAPTURE + vs_rise with pix_cnt != FRAME_PIXELS -> ARM, short_err pulsed one cycle, frame_cnt unchanged.
REQ-028 HOLD: frame_ready = 1 (registered, asserted first cycle in HOLD); buffer never written.
REQ-029 HOLD + release -> ARM if CONTINUOUS = 1 or a start was latched during HOLD; otherwise IDLE.
REQ-030 start in ARM, CAPTURE: ignored; start in HOLD: latched into start_pend, cleared on leaving HOLD.
REQ-031 24-bit timer cleared on entry to ARM from IDLE/HOLD, counts in ARM and CAPTURE, not cleared on short-frame retry.
REQ-032 Timer reaching TIMEOUT_CYC -> IDLE, timeout_err pulsed one cycle.
REQ-033 abort high: next state IDLE from any state; bram_we forced 0 the same cycle; abort has priority over all other transitions.
REQ-034 Simultaneous release and abort in HOLD: IDLE, start_pend cleared.
REQ-035 busy = state is ARM or CAPTURE, registered with state.

Reset
REQ-036 rst: state IDLE, frame_ready 0, busy 0, frame_cnt 0, short_err 0, timeout_err 0, pix_cnt 0, timer 0, start_pend 0, vsync_q 1.
REQ-037 rst mid-CAPTURE: bram_we 0 from the cycle rst is sampled high; the partial frame is discarded.
REQ-038 rst has priority over abort and all other inputs.

Structure
REQ-039 Shared package frame_pkg holds FRAME_PIXELS, state encoding localparams, and 17-bit address width.
REQ-040 Single module, no sub-modules; timer and pixel counter inline.

Verification
REQ-041 rst, start, vsync high 10 cycles then low, 76800 cap_we pulses at addr 0..76799, vsync high -> frame_ready 1, frame_cnt 1, 76800 bram_we pulses.
REQ-042 start while vsync low mid-frame -> zero bram_we until the next vsync fall, then full frame captured.
REQ-043 Frame with 76000 writes then vsync rise -> short_err one pulse, state ARM, frame_ready 0, frame_cnt unchanged.
REQ-044 TIMEOUT_CYC = 1000, start, vsync held high -> timeout_err at cycle 1000, state IDLE, busy 0.
REQ-045 HOLD, cap_we pulses on addr 5 -> bram_we stays 0; release with CONTINUOUS = 0 -> IDLE; start during HOLD, then release -> ARM.
REQ-046 abort at write 40000 of CAPTURE -> bram_we 0 same cycle, IDLE next cycle, frame_cnt unchanged.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the camera frame-capture controller: frame size,
// address width, FSM state encoding and a saturating counter helper.
package frame_pkg;

  // Address width covering one 320x240 frame buffer.
  localparam int unsigned ADDR_W = 17;

  // Pixel writes in one complete 320x240 frame (default for the controller).
  localparam int unsigned FRAME_PIXELS_DFLT = 76800;

  // State encoding, 2 bits.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ARM     = ST_ARM,
    S_CAPTURE = ST_CAPTURE,
    S_HOLD    = ST_HOLD
  } state_t;

  // Increment a counter, holding it at the limit once reached.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] cnt,
                                                input logic [ADDR_W-1:0] lim);
    if (cnt >= lim) begin
      return lim;
    end else begin
      return cnt + ADDR_W'(1);
    end
  endfunction

endpackage

// File: rtl/frame_capture_ctrl.sv
// Frame-capture controller: arms on a request, starts capturing only at a
// vsync fall, freezes a complete frame in HOLD until the consumer releases it,
// and aborts on short frames (retry), timeout, or an external abort.
module frame_capture_ctrl
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DFLT,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd2000000,
  parameter bit          CONTINUOUS   = 1'b0
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_cap_we,
  input  logic [ADDR_W-1:0] i_cap_addr,
  input  logic              i_start,
  input  logic              i_release,
  input  logic              i_abort,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_frame_ready,
  output logic              o_busy,
  output logic [7:0]        o_frame_cnt,
  output logic              o_short_err,
  output logic              o_timeout_err
);

  localparam logic [ADDR_W-1:0] LP_FRAME_PIX = ADDR_W'(FRAME_PIXELS);

  state_t            r_state;
  state_t            w_next;
  logic              r_vsync_q;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [23:0]       r_timer;
  logic              r_start_pend;
  logic              r_frame_ready;
  logic              r_busy;
  logic [7:0]        r_frame_cnt;
  logic              r_short_err;
  logic              r_timeout_err;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_run;
  logic w_accept;
  logic w_timeout;
  logic w_short;
  logic w_tout_evt;
  logic w_done;

  assign w_vs_rise = i_vsync & ~r_vsync_q;
  assign w_vs_fall = ~i_vsync & r_vsync_q;
  assign w_run     = (r_state == S_ARM) || (r_state == S_CAPTURE);
  assign w_timeout = w_run && (r_timer >= (TIMEOUT_CYC - 24'd1));

  // Write gate is combinational so the buffer sees the strobe with zero
  // latency; reset and abort kill it in the very cycle they are asserted.
  assign w_accept    = i_cap_we & (i_cap_addr < LP_FRAME_PIX) & (r_state == S_CAPTURE)
                     & ~i_abort & ~i_rst;
  assign o_bram_we   = w_accept;
  assign o_bram_addr = i_cap_addr;

  assign o_frame_ready = r_frame_ready;
  assign o_busy        = r_busy;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_short_err   = r_short_err;
  assign o_timeout_err = r_timeout_err;

  // Next-state decision: abort first, then timeout, then per-state transitions.
  always_comb begin
    w_next     = r_state;
    w_short    = 1'b0;
    w_tout_evt = 1'b0;
    w_done     = 1'b0;
    if (i_abort) begin
      w_next = S_IDLE;
    end else if (w_timeout) begin
      w_next     = S_IDLE;
      w_tout_evt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) w_next = S_ARM;
          else         w_next = S_IDLE;
        end
        S_ARM: begin
          if (w_vs_fall) w_next = S_CAPTURE;
          else           w_next = S_ARM;
        end
        S_CAPTURE: begin
          if (w_vs_rise) begin
            if (r_pix_cnt == LP_FRAME_PIX) begin
              w_next = S_HOLD;
              w_done = 1'b1;
            end else begin
              w_next  = S_ARM;
              w_short = 1'b1;
            end
          end else begin
            w_next = S_CAPTURE;
          end
        end
        S_HOLD: begin
          if (i_release) begin
            if (CONTINUOUS || r_start_pend || i_start) w_next = S_ARM;
            else                                       w_next = S_IDLE;
          end else begin
            w_next = S_HOLD;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_vsync_q     <= 1'b1;
      r_pix_cnt     <= '0;
      r_timer       <= 24'd0;
      r_start_pend  <= 1'b0;
      r_frame_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_short_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_vsync_q     <= i_vsync;
      r_state       <= w_next;
      r_busy        <= (w_next == S_ARM) || (w_next == S_CAPTURE);
      r_frame_ready <= (w_next == S_HOLD);
      r_short_err   <= w_short;
      r_timeout_err <= w_tout_evt;

      if (w_done) r_frame_cnt <= r_frame_cnt + 8'd1;
      else        r_frame_cnt <= r_frame_cnt;

      // Count restarts at the vsync fall that opens a capture.
      if ((r_state == S_ARM) && (w_next == S_CAPTURE)) r_pix_cnt <= '0;
      else if (w_accept) r_pix_cnt <= sat_inc(r_pix_cnt, LP_FRAME_PIX);
      else               r_pix_cnt <= r_pix_cnt;

      // Timer spans a whole request, so short-frame retries keep counting.
      if ((w_next == S_ARM) && ((r_state == S_IDLE) || (r_state == S_HOLD))) r_timer <= 24'd0;
      else if (w_run) r_timer <= r_timer + 24'd1;
      else            r_timer <= r_timer;

      // A start seen while a frame is frozen is remembered until HOLD ends.
      if ((r_state == S_HOLD) && (w_next == S_HOLD)) begin
        if (i_start) r_start_pend <= 1'b1;
        else         r_start_pend <= r_start_pend;
      end else begin
        r_start_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl, using a 64-pixel frame and a
// 1000-cycle timeout so every scenario fits in a short run.
module tb_frame_capture_ctrl;
  import frame_pkg::*;

  localparam int unsigned NPIX = 64;

  logic              pclk;
  logic              rst;
  logic              vsync;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic              start;
  logic              rel;
  logic              abort_in;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic              frame_ready;
  logic              busy;
  logic [7:0]        frame_cnt;
  logic              short_err;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  frame_capture_ctrl #(
    .FRAME_PIXELS(NPIX),
    .TIMEOUT_CYC (24'd1000),
    .CONTINUOUS  (1'b0)
  ) dut (
    .i_pclk       (pclk),
    .i_rst        (rst),
    .i_vsync      (vsync),
    .i_cap_we     (cap_we),
    .i_cap_addr   (cap_addr),
    .i_start      (start),
    .i_release    (rel),
    .i_abort      (abort_in),
    .o_bram_we    (bram_we),
    .o_bram_addr  (bram_addr),
    .o_frame_ready(frame_ready),
    .o_busy       (busy),
    .o_frame_cnt  (frame_cnt),
    .o_short_err  (short_err),
    .o_timeout_err(timeout_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // Inputs are applied at a falling edge; count the gated write, then move
  // to the next falling edge (one rising edge in between).
  task automatic step();
    #1;
    if (bram_we === 1'b1) we_cnt++;
    @(negedge pclk);
  endtask

  // Request a frame from IDLE and capture n writes at addresses 0..n-1,
  // finishing with the vsync rise that ends the frame.
  task automatic arm_and_capture(input int n);
    we_cnt = 0;
    vsync = 1'b1; start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    vsync = 1'b0; step();
    for (int i = 0; i < n; i++) begin
      cap_we = 1'b1; cap_addr = ADDR_W'(i); step();
    end
    cap_we = 1'b0;
    vsync = 1'b1; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 1'b0; cap_we = 1'b1; cap_addr = 17'd5;
    step(); step();
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL rst_bram_we: got %b want 0", bram_we); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_frame_ready: got %b want 0", frame_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL rst_short_err: got %b want 0", short_err); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    checks++; if (dut.r_vsync_q !== 1'b1) begin errors++; $display("FAIL rst_vsync_q: got %b want 1", dut.r_vsync_q); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    rst = 1'b0; vsync = 1'b1; cap_we = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    we_cnt = 0;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_arm_busy: got %b want 1", busy); end
    for (int i = 0; i < 10; i++) begin
      cap_we = 1'b1; cap_addr = 17'd3; step();
    end
    cap_we = 1'b0;
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL full_no_we_in_arm: got %0d want 0", we_cnt); end
    vsync = 1'b0; step();
    checks++; if (dut.r_state !== ST_CAPTURE) begin errors++; $display("FAIL full_capture_state: got %0d want %0d", dut.r_state, ST_CAPTURE); end
    for (int i = 0; i < int'(NPIX); i++) begin
      cap_we = 1'b1; cap_addr = ADDR_W'(i); step();
    end
    cap_we = 1'b1; cap_addr = 17'd64; #1;
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL full_out_of_range: got %b want 0", bram_we); end
    step(); cap_we = 1'b0;
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready_early: got %b want 0", frame_ready); end
    vsync = 1'b1; step();
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL full_frame_ready: got %b want 1", frame_ready); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL full_frame_cnt: got %0d want 1", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_hold: got %b want 0", busy); end
    checks++; if (we_cnt !== int'(NPIX)) begin errors++; $display("FAIL full_we_count: got %0d want %0d", we_cnt, NPIX); end
  endtask

  task automatic test_hold();
    cap_we = 1'b1; cap_addr = 17'd5; #1;
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL hold_no_write: got %b want 0", bram_we); end
    step(); cap_we = 1'b0;
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_kept: got %b want 1", frame_ready); end
    rel = 1'b1; step(); rel = 1'b0;
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL hold_release_ready: got %b want 0", frame_ready); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL hold_release_idle: got %0d want %0d", dut.r_state, ST_IDLE); end
    arm_and_capture(int'(NPIX));
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL hold_frame_cnt2: got %0d want 2", frame_cnt); end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL hold_start_stays: got %b want 1", frame_ready); end
    rel = 1'b1; step(); rel = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_pend_rearm_busy: got %b want 1", busy); end
    checks++; if (dut.r_state !== ST_ARM) begin errors++; $display("FAIL hold_pend_rearm_state: got %0d want %0d", dut.r_state, ST_ARM); end
    abort_in = 1'b1; step(); abort_in = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_mid_frame();
    vsync = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cap_we = 1'b1; cap_addr = ADDR_W'(i); step();
    end
    cap_we = 1'b0;
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL mid_no_write: got %0d want 0", we_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_armed: got %b want 1", busy); end
    vsync = 1'b1; step(); step();
    vsync = 1'b0; step();
    we_cnt = 0;
    for (int i = 0; i < int'(NPIX); i++) begin
      cap_we = 1'b1; cap_addr = ADDR_W'(i); step();
    end
    cap_we = 1'b0;
    vsync = 1'b1; step();
    checks++; if (we_cnt !== int'(NPIX)) begin errors++; $display("FAIL mid_we_count: got %0d want %0d", we_cnt, NPIX); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL mid_frame_ready: got %b want 1", frame_ready); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL mid_frame_cnt: got %0d want 3", frame_cnt); end
    rel = 1'b1; step(); rel = 1'b0;
  endtask

  task automatic test_short();
    arm_and_capture(60);
    checks++; if (short_err !== 1'b1) begin errors++; $display("FAIL short_pulse: got %b want 1", short_err); end
    checks++; if (dut.r_state !== ST_ARM) begin errors++; $display("FAIL short_state: got %0d want %0d", dut.r_state, ST_ARM); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL short_ready: got %b want 0", frame_ready); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL short_frame_cnt: got %0d want 3", frame_cnt); end
    step();
    checks++; if (short_err !== 1'b0) begin errors++; $display("FAIL short_one_cycle: got %b want 0", short_err); end
    abort_in = 1'b1; step(); abort_in = 1'b0;
  endtask

  task automatic test_timeout();
    vsync = 1'b1; step();
    start = 1'b1; step(); start = 1'b0;
    repeat (999) step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tout_early: got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tout_busy_before: got %b want 1", busy); end
    step();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tout_pulse: got %b want 1", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tout_busy_after: got %b want 0", busy); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL tout_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    step();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tout_one_cycle: got %b want 0", timeout_err); end
  endtask

  task automatic test_abort();
    we_cnt = 0;
    vsync = 1'b1; start = 1'b1; step(); start = 1'b0;
    step();
    vsync = 1'b0; step();
    for (int i = 0; i < 40; i++) begin
      cap_we = 1'b1; cap_addr = ADDR_W'(i); step();
    end
    cap_we = 1'b1; cap_addr = 17'd40; abort_in = 1'b1; #1;
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL abort_same_cycle: got %b want 0", bram_we); end
    step(); abort_in = 1'b0; cap_we = 1'b0;
    checks++; if (we_cnt !== 40) begin errors++; $display("FAIL abort_we_count: got %0d want 40", we_cnt); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL abort_frame_cnt: got %0d want 3", frame_cnt); end
  endtask

  task automatic test_rst_mid_capture();
    vsync = 1'b1; start = 1'b1; step(); start = 1'b0;
    step();
    vsync = 1'b0; step();
    for (int i = 0; i < 10; i++) begin
      cap_we = 1'b1; cap_addr = ADDR_W'(i); step();
    end
    cap_we = 1'b1; cap_addr = 17'd10; rst = 1'b1; abort_in = 1'b0; #1;
    checks++; if (bram_we !== 1'b0) begin errors++; $display("FAIL rstcap_same_cycle: got %b want 0", bram_we); end
    step(); rst = 1'b0; cap_we = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstcap_busy: got %b want 0", busy); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rstcap_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rstcap_state: got %0d want %0d", dut.r_state, ST_IDLE); end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; cap_we = 1'b0; cap_addr = '0;
    start = 1'b0; rel = 1'b0; abort_in = 1'b0;
    @(negedge pclk);
    test_reset();
    test_full_frame();
    test_hold();
    test_mid_frame();
    test_short();
    test_timeout();
    test_abort();
    test_rst_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
